mpsoc_spram_axi4_master: RTL and testbench

- Bridges a native single-port memory request interface (req/gnt/rvalid) to an AXI4 master port.
- It is the initiator counterpart of mpsoc_axi4_spram: a core or DMA port drives native requests, and this block issues single-beat AXI4 INCR transactions toward a slave.
- At most one transaction is outstanding. Response data and status return on the native side.

---
 rtl/mpsoc_spram_axi4_master_if.sv | 88 ++++++++
 rtl/mpsoc_spram_axi4_master.sv | 215 +++++++++++++++++++++
 tb/tb_mpsoc_spram_axi4_master.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_spram_axi4_master_if.sv
// AXI4 bundle used by mpsoc_spram_axi4_master.
// The master modport drives AW/W/AR and the B/R ready signals.
interface mpsoc_spram_axi4_master_if #(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = 8,
  parameter int USER_WIDTH = 10
) ();
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic [USER_WIDTH-1:0] aw_user;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic [USER_WIDTH-1:0] w_user;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );
endinterface

// File: rtl/mpsoc_spram_axi4_master.sv
// Native req/gnt/rvalid port to single-beat AXI4 master.
// One transaction in flight; response returns as a one-cycle rvalid pulse.
module mpsoc_spram_axi4_master #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_STRB_WIDTH = 8,
  parameter int AXI_USER_WIDTH = 10,
  parameter int MASTER_ID      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  mpsoc_spram_axi4_master_if.master axi
);

  localparam logic [2:0] SIZE = 3'($clog2(AXI_STRB_WIDTH));
  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(MASTER_ID);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    AR,
    WAIT_R
  } state_t;

  state_t state;
  state_t state_n;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_STRB_WIDTH-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic aw_done;
  logic aw_done_n;
  logic w_done;
  logic w_done_n;
  logic rvalid_q;
  logic err_q;

  logic gnt;
  logic aw_valid;
  logic w_valid;
  logic b_ready;
  logic ar_valid;
  logic r_ready;
  logic done;
  logic err_n;
  logic cap;

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    gnt       = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    done      = 1'b0;
    err_n     = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        gnt       = req_i;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        if (req_i) begin
          state_n = we_i ? WR : AR;
        end
      end
      WR: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if (aw_valid && axi.aw_ready) begin
          aw_done_n = 1'b1;
        end
        if (w_valid && axi.w_ready) begin
          w_done_n = 1'b1;
        end
        // B is only accepted once both AW and W have gone out
        if (aw_done_n && w_done_n) begin
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        b_ready = 1'b1;
        if (axi.b_valid) begin
          state_n = IDLE;
          done    = 1'b1;
          err_n   = axi.b_resp[1];
        end
      end
      AR: begin
        ar_valid = 1'b1;
        if (axi.ar_ready) begin
          state_n = WAIT_R;
        end
      end
      WAIT_R: begin
        r_ready = 1'b1;
        if (axi.r_valid) begin
          state_n = IDLE;
          done    = 1'b1;
          err_n   = axi.r_resp[1];
          cap     = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
    end else if (gnt) begin
      addr_q <= addr_i;
      be_q   <= be_i;
      data_q <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= done;
      err_q    <= err_n;
      if (cap) begin
        rdata_q <= axi.r_data;
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  assign axi.aw_valid  = aw_valid;
  assign axi.aw_id     = ID;
  assign axi.aw_addr   = addr_q;
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = SIZE;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'b0010;
  assign axi.aw_prot   = 3'b000;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_user   = '0;

  assign axi.w_valid = w_valid;
  assign axi.w_data  = data_q;
  assign axi.w_strb  = be_q;
  assign axi.w_last  = 1'b1;
  assign axi.w_user  = '0;

  assign axi.b_ready = b_ready;

  assign axi.ar_valid  = ar_valid;
  assign axi.ar_id     = ID;
  assign axi.ar_addr   = addr_q;
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = SIZE;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'b0010;
  assign axi.ar_prot   = 3'b000;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_user   = '0;

  assign axi.r_ready = r_ready;

  logic unused;
  assign unused = ^{axi.b_id, axi.b_user, axi.b_resp[0],
                    axi.r_id, axi.r_user, axi.r_resp[0],
                    axi.r_last};

endmodule

// File: tb/tb_mpsoc_spram_axi4_master.sv
// Bench for mpsoc_spram_axi4_master: vector table, AXI slave model,
// scoreboard of expected native responses.
module tb_mpsoc_spram_axi4_master;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          rsp_dly;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic        hold;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  localparam int NV = 10;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [63:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] data_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;

  int n_tests;
  int n_fail;

  vec_t tbl [NV];
  vec_t rst_vec;
  vec_t wr_list[$];
  vec_t rd_list[$];
  exp_t sb[$];

  int aw_hs_n;
  int w_hs_n;
  int b_n;
  int ar_hs_n;
  int r_n;

  mpsoc_spram_axi4_master_if #(
    .ID_WIDTH(10), .ADDR_WIDTH(64), .DATA_WIDTH(64),
    .STRB_WIDTH(8), .USER_WIDTH(10)
  ) axi ();

  mpsoc_spram_axi4_master #(
    .AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
    .AXI_STRB_WIDTH(8), .AXI_USER_WIDTH(10), .MASTER_ID(0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .be_i(be_i),
    .data_i(data_i),
    .gnt_o(gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .err_o(err_o),
    .axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // ---------------- AXI slave model ----------------
  initial begin : aw_slave
    int awc = 0;
    axi.aw_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.aw_ready = 1'b0;
        awc = 0;
      end else if (axi.aw_ready) begin
        axi.aw_ready = 1'b0;
      end else if (axi.aw_valid) begin
        if (awc >= wr_list[aw_hs_n].aw_dly) begin
          axi.aw_ready = 1'b1;
          awc = 0;
        end else awc++;
      end
    end
  end

  initial begin : w_slave
    int wc = 0;
    axi.w_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.w_ready = 1'b0;
        wc = 0;
      end else if (axi.w_ready) begin
        axi.w_ready = 1'b0;
      end else if (axi.w_valid) begin
        if (wc >= wr_list[w_hs_n].w_dly) begin
          axi.w_ready = 1'b1;
          wc = 0;
        end else wc++;
      end
    end
  end

  initial begin : b_slave
    int bc = 0;
    bit tk;
    axi.b_valid = 1'b0;
    axi.b_resp  = 2'b00;
    axi.b_id    = '0;
    axi.b_user  = '0;
    forever begin
      @(negedge clk);
      tk = axi.b_valid && axi.b_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.b_valid = 1'b0;
        bc = 0;
      end else begin
        if (tk) axi.b_valid = 1'b0;
        if (!axi.b_valid && aw_hs_n > b_n && w_hs_n > b_n) begin
          if (bc >= wr_list[b_n].rsp_dly) begin
            axi.b_valid = 1'b1;
            axi.b_resp  = wr_list[b_n].resp;
            bc = 0;
          end else bc++;
        end
      end
    end
  end

  initial begin : ar_slave
    int arc = 0;
    axi.ar_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.ar_ready = 1'b0;
        arc = 0;
      end else if (axi.ar_ready) begin
        axi.ar_ready = 1'b0;
      end else if (axi.ar_valid) begin
        if (arc >= rd_list[ar_hs_n].ar_dly) begin
          axi.ar_ready = 1'b1;
          arc = 0;
        end else arc++;
      end
    end
  end

  initial begin : r_slave
    int rc = 0;
    bit tk;
    axi.r_valid = 1'b0;
    axi.r_data  = '0;
    axi.r_resp  = 2'b00;
    axi.r_last  = 1'b1;
    axi.r_id    = '0;
    axi.r_user  = '0;
    forever begin
      @(negedge clk);
      tk = axi.r_valid && axi.r_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        axi.r_valid = 1'b0;
        rc = 0;
      end else begin
        if (tk) axi.r_valid = 1'b0;
        if (!axi.r_valid && ar_hs_n > r_n) begin
          if (rc >= rd_list[r_n].rsp_dly) begin
            axi.r_valid = 1'b1;
            axi.r_data  = rd_list[r_n].rdata;
            axi.r_resp  = rd_list[r_n].resp;
            rc = 0;
          end else rc++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        aw_hs_n = wr_list.size();
        w_hs_n  = wr_list.size();
        b_n     = wr_list.size();
        ar_hs_n = rd_list.size();
        r_n     = rd_list.size();
      end else begin
        if (axi.aw_valid) begin
          chk("aw_addr", axi.aw_addr, wr_list[aw_hs_n].addr);
          if (axi.aw_ready) begin
            chk("aw_len", 64'(axi.aw_len), 64'd0);
            chk("aw_size", 64'(axi.aw_size), 64'd3);
            chk("aw_burst", 64'(axi.aw_burst), 64'd1);
            chk("aw_id", 64'(axi.aw_id), 64'd0);
            aw_hs_n++;
          end
        end
        if (axi.w_valid) begin
          chk("w_data", axi.w_data, wr_list[w_hs_n].data);
          chk("w_strb", 64'(axi.w_strb), 64'(wr_list[w_hs_n].be));
          if (axi.w_ready) begin
            chk1("w_last", axi.w_last, 1'b1);
            w_hs_n++;
          end
        end
        if (axi.aw_valid || axi.w_valid)
          chk1("b_ready_in_wr", axi.b_ready, 1'b0);
        if (axi.b_valid && axi.b_ready) b_n++;
        if (axi.ar_valid) begin
          chk("ar_addr", axi.ar_addr, rd_list[ar_hs_n].addr);
          if (axi.ar_ready) begin
            chk("ar_len", 64'(axi.ar_len), 64'd0);
            chk("ar_size", 64'(axi.ar_size), 64'd3);
            chk("ar_burst", 64'(axi.ar_burst), 64'd1);
            ar_hs_n++;
          end
        end
        if (axi.r_valid && axi.r_ready) r_n++;
        if (rvalid_o) begin
          if (sb.size() == 0) begin
            chk1("rvalid_spurious", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("rdata", rdata_o, e.rdata);
            chk1("err", err_o, e.err);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input vec_t v, input bit after_hold);
    int t = 0;
    req_i  = 1'b1;
    we_i   = v.we;
    addr_i = v.addr;
    be_i   = v.be;
    data_i = v.data;
    @(negedge clk);
    while (!gnt_o && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk1("gnt", gnt_o, 1'b1);
    if (after_hold) chk1("gnt_with_rvalid", rvalid_o, 1'b1);
    else chk("gnt_latency", 64'(t), 64'd0);
    chk("no_valid_at_gnt",
        64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'd0);
    if (gnt_o) begin
      sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      if (v.we) wr_list.push_back(v);
      else rd_list.push_back(v);
    end
  endtask

  task automatic wait_done(input vec_t v);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk1("complete", sb.size() == 0, 1'b1);
    @(negedge clk);
    chk1("rvalid_one_cycle", rvalid_o, 1'b0);
    chk("rdata_hold", rdata_o, v.exp_rdata);
  endtask

  task automatic reset_seq();
    @(posedge clk); #1;
    issue(rst_vec, 1'b0);
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_pre_aw_valid", axi.aw_valid, 1'b1);
    chk1("rst_pre_w_valid", axi.w_valid, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_aw_valid", axi.aw_valid, 1'b0);
    chk1("rst_w_valid", axi.w_valid, 1'b0);
    chk1("rst_ar_valid", axi.ar_valid, 1'b0);
    chk1("rst_b_ready", axi.b_ready, 1'b0);
    chk1("rst_r_ready", axi.r_ready, 1'b0);
    chk1("rst_rvalid", rvalid_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_aw_cache", 64'(axi.aw_cache), 64'd2);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ar0 = 0;
    tbl[0] = '{we:1, addr:64'h1000, be:8'hFF, data:64'hDEADBEEF_CAFEF00D,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b00,
               rdata:64'd0, hold:0, exp_rdata:64'd0, exp_err:0};
    tbl[1] = '{we:1, addr:64'h1008, be:8'h0F, data:64'h11112222_33334444,
               aw_dly:3, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b00,
               rdata:64'd0, hold:0, exp_rdata:64'd0, exp_err:0};
    tbl[2] = '{we:0, addr:64'h2008, be:8'h00, data:64'd0,
               aw_dly:0, w_dly:0, ar_dly:2, rsp_dly:0, resp:2'b00,
               rdata:64'h01234567_89ABCDEF, hold:0,
               exp_rdata:64'h01234567_89ABCDEF, exp_err:0};
    tbl[3] = '{we:0, addr:64'h2040, be:8'h00, data:64'd0,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:1, resp:2'b10,
               rdata:64'hBADC0FFE_E0DDF00D, hold:0,
               exp_rdata:64'hBADC0FFE_E0DDF00D, exp_err:1};
    tbl[4] = '{we:1, addr:64'h1010, be:8'hF0, data:64'h55556666_77778888,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b11,
               rdata:64'd0, hold:0,
               exp_rdata:64'hBADC0FFE_E0DDF00D, exp_err:1};
    tbl[5] = '{we:1, addr:64'h1018, be:8'h3C, data:64'h99990000_AAAABBBB,
               aw_dly:0, w_dly:2, ar_dly:0, rsp_dly:2, resp:2'b00,
               rdata:64'd0, hold:0,
               exp_rdata:64'hBADC0FFE_E0DDF00D, exp_err:0};
    tbl[6] = '{we:0, addr:64'h2010, be:8'h00, data:64'd0,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b00,
               rdata:64'hA5A5A5A5_A5A5A5A5, hold:1,
               exp_rdata:64'hA5A5A5A5_A5A5A5A5, exp_err:0};
    tbl[7] = '{we:0, addr:64'h2018, be:8'h00, data:64'd0,
               aw_dly:0, w_dly:0, ar_dly:1, rsp_dly:0, resp:2'b01,
               rdata:64'h5A5A5A5A_5A5A5A5A, hold:0,
               exp_rdata:64'h5A5A5A5A_5A5A5A5A, exp_err:0};
    tbl[8] = '{we:1, addr:64'h3000, be:8'hFF, data:64'h77777777_77777777,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b00,
               rdata:64'd0, hold:0, exp_rdata:64'd0, exp_err:0};
    tbl[9] = '{we:0, addr:64'h3000, be:8'h00, data:64'd0,
               aw_dly:0, w_dly:0, ar_dly:0, rsp_dly:1, resp:2'b11,
               rdata:64'h0F0F0F0F_0F0F0F0F, hold:0,
               exp_rdata:64'h0F0F0F0F_0F0F0F0F, exp_err:1};
    rst_vec = '{we:1, addr:64'h1F00, be:8'hFF, data:64'h88888888_88888888,
                aw_dly:5, w_dly:0, ar_dly:0, rsp_dly:0, resp:2'b00,
                rdata:64'd0, hold:0, exp_rdata:64'd0, exp_err:0};

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    be_i    = '0;
    data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_gnt", gnt_o, 1'b0);
    chk1("reset_rvalid", rvalid_o, 1'b0);
    chk1("reset_err", err_o, 1'b0);
    chk("reset_rdata", rdata_o, 64'd0);
    chk("reset_valids",
        64'({axi.aw_valid, axi.w_valid, axi.ar_valid,
             axi.b_ready, axi.r_ready}), 64'd0);
    chk("reset_aw_cache", 64'(axi.aw_cache), 64'd2);
    chk("reset_ar_size", 64'(axi.ar_size), 64'd3);
    chk("reset_ar_burst", 64'(axi.ar_burst), 64'd1);
    chk1("reset_w_last", axi.w_last, 1'b1);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i == 8) reset_seq();
      if (i == 6) ar0 = ar_hs_n;
      @(posedge clk); #1;
      issue(tbl[i], i > 0 && tbl[i-1].hold);
      if (!tbl[i].hold) begin
        @(posedge clk); #1;
        req_i = 1'b0;
        if (tbl[i].we)
          chk1("valid_after_gnt", axi.aw_valid && axi.w_valid, 1'b1);
        else
          chk1("valid_after_gnt", axi.ar_valid, 1'b1);
        wait_done(tbl[i]);
      end
      if (i == 7) chk("b2b_ar_count", 64'(ar_hs_n - ar0), 64'd2);
    end

    repeat (3) @(negedge clk);
    chk("aw_count", 64'(aw_hs_n), 64'(wr_list.size()));
    chk("w_count", 64'(w_hs_n), 64'(wr_list.size()));
    chk("b_count", 64'(b_n), 64'(wr_list.size()));
    chk("ar_count", 64'(ar_hs_n), 64'(rd_list.size()));
    chk("r_count", 64'(r_n), 64'(rd_list.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
